lock_key_loader: RTL and testbench

- Upstream key-delivery stage for the logic-locked c432 netlist. It drives that netlist's k0..k2 inputs as key[0..2].
- Accepts the key serially over a valid/ready bit stream, followed by a check field. Verifies the check, then applies the key.
- Until a verified key is present, the key outputs are held at a decoy value, so the locked netlist produces corrupted outputs.
- Counts failed loads and locks out permanently (until reset) after a set number of failures. This is the fault-analysis surface for glitch and skip attacks on key delivery.

---
 rtl/lock_key_pkg.sv | 36 +++
 rtl/lock_key_check.sv | 37 +++
 rtl/lock_key_loader.sv | 137 +++++++++++++
 tb/tb_lock_key_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_key_pkg.sv
// Shared types and helpers for the c432 key loader.
// Optional feature macro: LOCK_KEY_LOADER_CRC_EN.
// - Undefined: the check field is one even-parity bit.
// - Defined: the check field is a 4-bit CRC.
package lock_key_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      CHECK,
      ACTIVE,
      LOCKOUT
   } state_t;

   // CRC-4 polynomial x^4+x+1; the x^4 term is implicit.
   localparam logic [3:0] CRC4_POLY = 4'b0011;

`ifdef LOCK_KEY_LOADER_CRC_EN
   localparam int CHK_W = 4;
`else
   localparam int CHK_W = 1;
`endif

   // Running even parity: fold one more key bit into the accumulator.
   function automatic logic parity_step(input logic acc, input logic b);
      return acc ^ b;
   endfunction

   // Serial CRC-4 update, MSB-first data.
   function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic b);
      logic fb;
      fb = crc[3] ^ b;
      return {crc[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
   endfunction

endpackage

// File: rtl/lock_key_check.sv
// Running check over the streamed key bits.
// The comparison against the received check field is made on the frame's check bits.
// Optional feature macro: LOCK_KEY_LOADER_CRC_EN.
// - Defined: CRC-4.
// - Undefined: even parity.
module lock_key_check
   import lock_key_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic             din,
   input  logic [CHK_W-1:0] chk_rx,
   output logic             pass
);

   logic [CHK_W-1:0] acc;

   // Accumulate the check over key bits only; restart at every frame start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
`ifdef LOCK_KEY_LOADER_CRC_EN
         acc <= crc4_step(acc, din);
`else
         acc <= parity_step(acc, din);
`endif
      end
   end

   assign pass = (acc == chk_rx);

endmodule

// File: rtl/lock_key_loader.sv
// Serial key loader for the logic-locked c432 netlist (drives k0..k2).
// A frame is KEY_W key bits followed by the check field, both MSB first.
// The key is applied only after the check passes. Until then the outputs carry a decoy value.
// Consecutive check failures are counted. When the count reaches MAX_FAIL, the loader locks out until reset.
// Optional feature macro: LOCK_KEY_LOADER_CRC_EN.
// - Undefined: the check field is one parity bit.
// - Defined: the check field is a 4-bit CRC.
module lock_key_loader
   import lock_key_pkg::*;
#(
   parameter int               KEY_W     = 3,
   parameter logic [KEY_W-1:0] KEY_DECOY = 3'b010,
   parameter int               MAX_FAIL  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_start,
   input  logic             sdata_valid,
   input  logic             sdata,
   output logic             sdata_ready,
   output logic [KEY_W-1:0] key,
   output logic             key_active,
   output logic             load_err,
   output logic [3:0]       fail_cnt,
   output logic             lockout
);

   localparam int               FRAME_W    = KEY_W + CHK_W;
   localparam int               CNT_W      = $clog2(FRAME_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] KEY_BITS   = CNT_W'(KEY_W);
   localparam logic [3:0]       MAX_FAIL_L = 4'(MAX_FAIL);

   // Failure counter increment that sticks at 15.
   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   state_t             state;
   logic [FRAME_W-1:0] shreg;
   logic [CNT_W-1:0]   bcnt;
   logic               bit_acc;
   logic               start_acc;
   logic               chk_en;
   logic               chk_pass;
   logic [3:0]         fail_next;

   // sdata_ready is registered and high only in SHIFT, so a handshake implies SHIFT.
   assign bit_acc   = sdata_valid && sdata_ready;
   assign start_acc = load_start && ((state == IDLE) || (state == ACTIVE));
   assign chk_en    = bit_acc && (bcnt < KEY_BITS);
   assign fail_next = sat_inc4(fail_cnt);

   lock_key_check u_check (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (start_acc),
      .en     (chk_en),
      .din    (sdata),
      .chk_rx (shreg[CHK_W-1:0]),
      .pass   (chk_pass)
   );

   // Load FSM: every output is registered with the state transition that implies it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         shreg       <= '0;
         bcnt        <= '0;
         sdata_ready <= 1'b0;
         key         <= KEY_DECOY;
         key_active  <= 1'b0;
         load_err    <= 1'b0;
         fail_cnt    <= 4'd0;
         lockout     <= 1'b0;
      end else begin
         load_err <= 1'b0;
         case (state)
            IDLE: begin
               if (load_start) begin
                  state       <= SHIFT;
                  sdata_ready <= 1'b1;
                  shreg       <= '0;
                  bcnt        <= '0;
               end
            end
            SHIFT: begin
               if (bit_acc) begin
                  shreg <= {shreg[FRAME_W-2:0], sdata};
                  bcnt  <= bcnt + CNT_W'(1);
                  if (bcnt == LAST_BIT) begin
                     state       <= CHECK;
                     sdata_ready <= 1'b0;
                  end
               end
            end
            CHECK: begin
               if (chk_pass) begin
                  state      <= ACTIVE;
                  key        <= shreg[FRAME_W-1 -: KEY_W];
                  key_active <= 1'b1;
                  fail_cnt   <= 4'd0;
               end else begin
                  load_err <= 1'b1;
                  fail_cnt <= fail_next;
                  if (fail_next == MAX_FAIL_L) begin
                     state   <= LOCKOUT;
                     lockout <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            ACTIVE: begin
               if (load_start) begin
                  state       <= SHIFT;
                  sdata_ready <= 1'b1;
                  shreg       <= '0;
                  bcnt        <= '0;
                  key         <= KEY_DECOY;
                  key_active  <= 1'b0;
               end
            end
            LOCKOUT: begin
               key         <= KEY_DECOY;
               key_active  <= 1'b0;
               sdata_ready <= 1'b0;
               lockout     <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lock_key_loader.sv
// Scoreboard bench for lock_key_loader.
// - Stimulus queues the expected outcome of each frame.
// - A negedge monitor pops one entry whenever the DUT reports a frame result (load_err pulse or key_active rising).
module tb_lock_key_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load_start = 1'b0;
   logic       sdata_valid = 1'b0;
   logic       sdata = 1'b0;
   logic       sdata_ready;
   logic [2:0] key;
   logic       key_active;
   logic       load_err;
   logic [3:0] fail_cnt;
   logic       lockout;

   always #5 clk = ~clk;

   lock_key_loader dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_start  (load_start),
      .sdata_valid (sdata_valid),
      .sdata       (sdata),
      .sdata_ready (sdata_ready),
      .key         (key),
      .key_active  (key_active),
      .load_err    (load_err),
      .fail_cnt    (fail_cnt),
      .lockout     (lockout)
   );

`ifdef LOCK_KEY_LOADER_CRC_EN
   localparam int         TB_CHK       = 4;
   localparam logic [3:0] CHK_101_GOOD = 4'b1111;
   localparam logic [3:0] CHK_101_BAD  = 4'b1110;
   localparam logic [3:0] CHK_011_GOOD = 4'b0101;
`else
   localparam int         TB_CHK       = 1;
   localparam logic [3:0] CHK_101_GOOD = 4'b0000;
   localparam logic [3:0] CHK_101_BAD  = 4'b0001;
   localparam logic [3:0] CHK_011_GOOD = 4'b0000;
`endif

   typedef struct {
      logic       err;
      logic [2:0] key;
      logic [3:0] fc;
      logic       lk;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_acc = -100;
   logic prev_ka = 1'b0;
   logic prev_le = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every frame result against the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (sdata_valid && sdata_ready) last_acc <= cyc;
         if (prev_le) chk("load_err_width", 32'(load_err), 32'd0);
         if (load_err || (key_active && !prev_ka)) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: got load_err=%0b key_active=%0b expected no event", load_err, key_active);
            end else begin
               mon_e = q.pop_front();
               chk("evt_load_err", 32'(load_err), 32'(mon_e.err));
               chk("evt_key", 32'(key), 32'(mon_e.key));
               chk("evt_key_active", 32'(key_active), 32'(!mon_e.err));
               chk("evt_fail_cnt", 32'(fail_cnt), 32'(mon_e.fc));
               chk("evt_lockout", 32'(lockout), 32'(mon_e.lk));
               chk("evt_latency", 32'(cyc - last_acc), 32'd2);
            end
         end
      end
      prev_ka <= key_active;
      prev_le <= load_err;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      tick(1);
      load_start = 1'b0;
   endtask

   task automatic send_bit(input logic b, input int gap);
      int w;
      w = 0;
      sdata = b;
      sdata_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (sdata_ready) break;
         w++;
         if (w > 20) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got sdata_ready=0 expected 1 within 20 cycles");
            break;
         end
      end
      tick(1);
      sdata_valid = 1'b0;
      if (gap > 0) tick(gap);
   endtask

   task automatic send_frame(input logic [2:0] k, input logic [3:0] c, input int gap);
      for (int i = 2; i >= 0; i--) send_bit(k[i], gap);
      for (int i = TB_CHK - 1; i >= 0; i--) send_bit(c[i], gap);
   endtask

   task automatic expect_evt(input logic err, input logic [2:0] k, input logic [3:0] fc, input logic lk);
      exp_t e;
      e.err = err;
      e.key = k;
      e.fc  = fc;
      e.lk  = lk;
      q.push_back(e);
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (q.size() != 0 && w < 50) begin
         tick(1);
         w++;
      end
      chk("drain_timeout", 32'(q.size()), 32'd0);
      tick(2);
   endtask

   initial begin
      int rdy_seen;
      // Reset values
      tick(2);
      chk("rst_key", 32'(key), 32'h2);
      chk("rst_key_active", 32'(key_active), 32'd0);
      chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
      chk("rst_lockout", 32'(lockout), 32'd0);
      chk("rst_sdata_ready", 32'(sdata_ready), 32'd0);
      chk("rst_load_err", 32'(load_err), 32'd0);
      rst_n = 1'b1;
      tick(2);

      // Good load with gaps between bits
      expect_evt(1'b0, 3'b101, 4'd0, 1'b0);
      pulse_start();
      send_frame(3'b101, CHK_101_GOOD, 2);
      drain();
      chk("good_key_held", 32'(key), 32'h5);

      // Reload from ACTIVE with a simultaneous bit: start wins, bit not consumed
      load_start = 1'b1;
      sdata_valid = 1'b1;
      sdata = 1'b1;
      tick(1);
      load_start = 1'b0;
      sdata_valid = 1'b0;
      chk("reload_key_decoy", 32'(key), 32'h2);
      chk("reload_key_active", 32'(key_active), 32'd0);
      chk("reload_ready", 32'(sdata_ready), 32'd1);
      expect_evt(1'b0, 3'b011, 4'd0, 1'b0);
      send_frame(3'b011, CHK_011_GOOD, 1);
      drain();

      // Bad check, then a good load clears the count
      pulse_start();
      expect_evt(1'b1, 3'b010, 4'd1, 1'b0);
      send_frame(3'b101, CHK_101_BAD, 0);
      drain();
      chk("bad_idle_ready", 32'(sdata_ready), 32'd0);
      chk("bad_key", 32'(key), 32'h2);
      chk("bad_fail_cnt", 32'(fail_cnt), 32'd1);
      expect_evt(1'b0, 3'b101, 4'd0, 1'b0);
      pulse_start();
      send_frame(3'b101, CHK_101_GOOD, 0);
      drain();

      // Three consecutive failures lock the loader out
      for (int n = 1; n <= 3; n++) begin
         pulse_start();
         expect_evt(1'b1, 3'b010, 4'(n), (n == 3));
         send_frame(3'b101, CHK_101_BAD, 0);
         drain();
      end
      chk("lk_lockout", 32'(lockout), 32'd1);
      chk("lk_fail_cnt", 32'(fail_cnt), 32'd3);
      pulse_start();
      sdata_valid = 1'b1;
      sdata = 1'b1;
      rdy_seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (sdata_ready) rdy_seen++;
         tick(1);
      end
      sdata_valid = 1'b0;
      chk("lk_ready_never", 32'(rdy_seen), 32'd0);
      chk("lk_key", 32'(key), 32'h2);
      chk("lk_key_active", 32'(key_active), 32'd0);
      chk("lk_still", 32'(lockout), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("lk_rst_lockout", 32'(lockout), 32'd0);
      chk("lk_rst_fail_cnt", 32'(fail_cnt), 32'd0);
      chk("lk_rst_key", 32'(key), 32'h2);
      tick(1);
      rst_n = 1'b1;
      tick(1);

      // Reset mid-SHIFT discards partial data
      pulse_start();
      send_bit(1'b1, 0);
      send_bit(1'b0, 0);
      chk("mid_in_shift", 32'(sdata_ready), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(sdata_ready), 32'd0);
      chk("mid_rst_key", 32'(key), 32'h2);
      chk("mid_rst_key_active", 32'(key_active), 32'd0);
      chk("mid_rst_fail_cnt", 32'(fail_cnt), 32'd0);
      chk("mid_rst_lockout", 32'(lockout), 32'd0);
      tick(1);
      rst_n = 1'b1;
      tick(2);
      chk("mid_idle_ready", 32'(sdata_ready), 32'd0);
      expect_evt(1'b0, 3'b101, 4'd0, 1'b0);
      pulse_start();
      send_frame(3'b101, CHK_101_GOOD, 1);
      drain();

      tick(5);
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
